// File: rtl/jump_stack_pkg.sv
// Shared definitions for the fetch return-address stack: default sizing and the
// per-cycle operation decode used by jump_stack.
package jump_stack_pkg;

    localparam int RAS_ADDR_W_DEF = 22;
    localparam int RAS_DEPTH_DEF  = 8;
    localparam int RAS_RET_OFFSET = 2;

    typedef enum logic [2:0] {
        RAS_HOLD,
        RAS_RESTORE,
        RAS_PUSH,
        RAS_POP,
        RAS_REPL
    } ras_op_e;

    // Collapse the strobes into one operation; empty-stack corner cases fold
    // into HOLD (pop) and PUSH (replace) so the datapath needs no extra checks.
    function automatic ras_op_e ras_decode(input logic restore, input logic valid,
                                           input logic jal, input logic jr,
                                           input logic empty);
        ras_op_e op;
        op = RAS_HOLD;
        if (restore)
            op = RAS_RESTORE;
        else if (valid) begin
            case ({jal, jr})
                2'b10:   op = RAS_PUSH;
                2'b01:   op = empty ? RAS_HOLD : RAS_POP;
                2'b11:   op = empty ? RAS_PUSH : RAS_REPL;
                default: op = RAS_HOLD;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/jump_stack.sv
// Return-address stack between the fetch pre-aligner and the PC mux: circular
// storage, overwrite-oldest on overflow, pointer checkpoint/restore for repair.
module jump_stack
    import jump_stack_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RAS_ADDR_W_DEF,
    parameter int DEPTH         = RAS_DEPTH_DEF,
    parameter int RET_OFFSET    = RAS_RET_OFFSET,
    localparam int PTR_W        = $clog2(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic                     i_jal_inst,
    input  logic                     i_jr_inst,
    input  logic [ADDRESS_WIDTH-1:0] i_branch_address,
    input  logic                     i_restore,
    input  logic [PTR_W-1:0]         i_restore_tos,
    input  logic [PTR_W:0]           i_restore_cnt,
    output logic [ADDRESS_WIDTH-1:0] o_pop_addr,
    output logic                     o_pop_valid,
    output logic [PTR_W-1:0]         o_tos,
    output logic [PTR_W:0]           o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]         tos_q, tos_d, tos_inc;
    logic [PTR_W:0]           cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] ret_addr;
    ras_op_e                  op;

    assign op       = ras_decode(i_restore, i_valid, i_jal_inst, i_jr_inst, cnt_q == '0);
    assign ret_addr = i_branch_address + ADDRESS_WIDTH'(RET_OFFSET);
    assign tos_inc  = tos_q + PTR_W'(1);

    always_comb begin
        mem_d = mem_q;
        tos_d = tos_q;
        cnt_d = cnt_q;
        case (op)
            RAS_RESTORE: begin
                tos_d = i_restore_tos;
                cnt_d = (i_restore_cnt > CNT_MAX) ? CNT_MAX : i_restore_cnt;
            end
            RAS_PUSH: begin
                // Full stack: tos advances onto the oldest slot and overwrites it.
                tos_d          = tos_inc;
                mem_d[tos_inc] = ret_addr;
                if (cnt_q != CNT_MAX)
                    cnt_d = cnt_q + 1'b1;
            end
            RAS_POP: begin
                tos_d = tos_q - PTR_W'(1);
                cnt_d = cnt_q - 1'b1;
            end
            RAS_REPL: mem_d[tos_q] = ret_addr;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tos_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= mem_d[i];
        end
    end

    assign o_pop_addr  = mem_q[tos_q];
    assign o_pop_valid = (cnt_q != '0);
    assign o_tos       = tos_q;
    assign o_count     = cnt_q;
    assign o_full      = (cnt_q == CNT_MAX);
    assign o_empty     = (cnt_q == '0);

endmodule

// File: tb/tb_jump_stack.sv
// Directed bench for jump_stack at AW=22, DEPTH=8, RET_OFFSET=2.
module tb_jump_stack;

    localparam int AW = 22;
    localparam int PW = 3;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_valid, i_jal_inst, i_jr_inst, i_restore;
    logic [AW-1:0] i_branch_address;
    logic [PW-1:0] i_restore_tos;
    logic [PW:0]   i_restore_cnt;
    logic [AW-1:0] o_pop_addr;
    logic          o_pop_valid, o_full, o_empty;
    logic [PW-1:0] o_tos;
    logic [PW:0]   o_count;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [PW-1:0] exp_tos = '0;
    logic [PW-1:0] saved_tos;

    always #5 i_clk = ~i_clk;

    jump_stack #(.ADDRESS_WIDTH(AW), .DEPTH(8), .RET_OFFSET(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_jal_inst(i_jal_inst),
        .i_jr_inst(i_jr_inst), .i_branch_address(i_branch_address), .i_restore(i_restore),
        .i_restore_tos(i_restore_tos), .i_restore_cnt(i_restore_cnt),
        .o_pop_addr(o_pop_addr), .o_pop_valid(o_pop_valid), .o_tos(o_tos),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
    );

    task automatic do_op(input logic v, input logic jal, input logic jr, input logic [AW-1:0] a);
        i_valid = v; i_jal_inst = jal; i_jr_inst = jr; i_branch_address = a;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_jal_inst = 1'b0; i_jr_inst = 1'b0; i_branch_address = '0;
    endtask

    task automatic do_restore(input logic [PW-1:0] t, input logic [PW:0] c, input logic with_jal);
        i_restore = 1'b1; i_restore_tos = t; i_restore_cnt = c;
        i_valid = with_jal; i_jal_inst = with_jal; i_branch_address = 22'h000099;
        @(posedge i_clk); #1;
        i_restore = 1'b0; i_restore_tos = '0; i_restore_cnt = '0;
        i_valid = 1'b0; i_jal_inst = 1'b0; i_branch_address = '0;
    endtask

    task automatic test_reset();
        #12;
        n_tests++; if (o_count !== 4'd0)  begin n_fail++; $display("FAIL rst_count got %0d want 0", o_count); end
        n_tests++; if (o_empty !== 1'b1)  begin n_fail++; $display("FAIL rst_empty got %b want 1", o_empty); end
        n_tests++; if (o_full !== 1'b0)   begin n_fail++; $display("FAIL rst_full got %b want 0", o_full); end
        n_tests++; if (o_pop_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pop_valid got %b want 0", o_pop_valid); end
        n_tests++; if (o_pop_addr !== 22'h0) begin n_fail++; $display("FAIL rst_pop_addr got %h want 0", o_pop_addr); end
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        do_op(1, 1, 0, 22'h20); do_op(1, 1, 0, 22'h30); do_op(1, 1, 0, 22'h40);
        n_tests++; if (o_count !== 4'd3)  begin n_fail++; $display("FAIL pre_rst_count got %0d want 3", o_count); end
        n_tests++; if (o_pop_addr !== 22'h42) begin n_fail++; $display("FAIL pre_rst_top got %h want 42", o_pop_addr); end
        #2 i_rst_n = 1'b0;
        #1;
        n_tests++; if (o_count !== 4'd0)  begin n_fail++; $display("FAIL async_rst_count got %0d want 0", o_count); end
        n_tests++; if (o_empty !== 1'b1)  begin n_fail++; $display("FAIL async_rst_empty got %b want 1", o_empty); end
        n_tests++; if (o_pop_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_pop_valid got %b want 0", o_pop_valid); end
        n_tests++; if (o_pop_addr !== 22'h0) begin n_fail++; $display("FAIL async_rst_pop_addr got %h want 0", o_pop_addr); end
        n_tests++; if (o_tos !== 3'd0)    begin n_fail++; $display("FAIL async_rst_tos got %0d want 0", o_tos); end
        #1 i_rst_n = 1'b1;
        exp_tos = '0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_push_pop();
        do_op(1, 1, 0, 22'h000100); exp_tos++;
        n_tests++; if (o_pop_addr !== 22'h000102) begin n_fail++; $display("FAIL push_addr got %h want 000102", o_pop_addr); end
        n_tests++; if (o_pop_valid !== 1'b1) begin n_fail++; $display("FAIL push_valid got %b want 1", o_pop_valid); end
        n_tests++; if (o_tos !== exp_tos)   begin n_fail++; $display("FAIL push_tos got %0d want %0d", o_tos, exp_tos); end
        do_op(1, 0, 1, 22'h000200); exp_tos--;
        n_tests++; if (o_count !== 4'd0)  begin n_fail++; $display("FAIL pop_count got %0d want 0", o_count); end
        n_tests++; if (o_empty !== 1'b1)  begin n_fail++; $display("FAIL pop_empty got %b want 1", o_empty); end
        n_tests++; if (o_tos !== exp_tos) begin n_fail++; $display("FAIL pop_tos got %0d want %0d", o_tos, exp_tos); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            do_op(1, 1, 0, 22'(32'h10 + i)); exp_tos++;
        end
        n_tests++; if (o_full !== 1'b1)   begin n_fail++; $display("FAIL ovf_full got %b want 1", o_full); end
        n_tests++; if (o_count !== 4'd8)  begin n_fail++; $display("FAIL ovf_count got %0d want 8", o_count); end
        n_tests++; if (o_pop_addr !== 22'h1A) begin n_fail++; $display("FAIL ovf_top got %h want 1a", o_pop_addr); end
        n_tests++; if (o_tos !== exp_tos) begin n_fail++; $display("FAIL ovf_tos got %0d want %0d", o_tos, exp_tos); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (o_pop_addr !== 22'(32'h1A - i)) begin
                n_fail++; $display("FAIL ovf_pop%0d got %h want %h", i, o_pop_addr, 22'(32'h1A - i));
            end
            do_op(1, 0, 1, 22'h0); exp_tos--;
        end
        n_tests++; if (o_empty !== 1'b1)  begin n_fail++; $display("FAIL ovf_drain_empty got %b want 1", o_empty); end
        n_tests++; if (o_tos !== exp_tos) begin n_fail++; $display("FAIL ovf_drain_tos got %0d want %0d", o_tos, exp_tos); end
    endtask

    task automatic test_underflow_gating();
        do_op(1, 0, 1, 22'h0);
        n_tests++; if (o_tos !== exp_tos) begin n_fail++; $display("FAIL udf_tos got %0d want %0d", o_tos, exp_tos); end
        n_tests++; if (o_count !== 4'd0)  begin n_fail++; $display("FAIL udf_count got %0d want 0", o_count); end
        n_tests++; if (o_pop_valid !== 1'b0) begin n_fail++; $display("FAIL udf_pop_valid got %b want 0", o_pop_valid); end
        do_op(0, 1, 0, 22'h000500);
        n_tests++; if (o_count !== 4'd0)  begin n_fail++; $display("FAIL gate_count got %0d want 0", o_count); end
        n_tests++; if (o_tos !== exp_tos) begin n_fail++; $display("FAIL gate_tos got %0d want %0d", o_tos, exp_tos); end
    endtask

    task automatic test_restore();
        do_op(1, 1, 0, 22'h50); exp_tos++;
        do_op(1, 1, 0, 22'h60); exp_tos++;
        saved_tos = exp_tos;
        do_op(1, 1, 0, 22'h70); do_op(1, 1, 0, 22'h80); do_op(1, 1, 0, 22'h90);
        n_tests++; if (o_count !== 4'd5) begin n_fail++; $display("FAIL rs_pre_count got %0d want 5", o_count); end
        do_restore(saved_tos, 4'd2, 1'b1); exp_tos = saved_tos;
        n_tests++; if (o_count !== 4'd2)  begin n_fail++; $display("FAIL rs_count got %0d want 2", o_count); end
        n_tests++; if (o_tos !== exp_tos) begin n_fail++; $display("FAIL rs_tos got %0d want %0d", o_tos, exp_tos); end
        n_tests++; if (o_pop_addr !== 22'h62) begin n_fail++; $display("FAIL rs_top got %h want 62", o_pop_addr); end
        do_restore(saved_tos, 4'd15, 1'b0);
        n_tests++; if (o_count !== 4'd8)  begin n_fail++; $display("FAIL rs_clamp_count got %0d want 8", o_count); end
        n_tests++; if (o_full !== 1'b1)   begin n_fail++; $display("FAIL rs_clamp_full got %b want 1", o_full); end
        do_restore(saved_tos, 4'd0, 1'b0);
        n_tests++; if (o_empty !== 1'b1)  begin n_fail++; $display("FAIL rs_zero_empty got %b want 1", o_empty); end
    endtask

    task automatic test_wrap_replace();
        do_op(1, 1, 0, 22'h3FFFFF); exp_tos++;
        n_tests++; if (o_pop_addr !== 22'h000001) begin n_fail++; $display("FAIL wrap_addr got %h want 000001", o_pop_addr); end
        n_tests++; if (o_count !== 4'd1)  begin n_fail++; $display("FAIL wrap_count got %0d want 1", o_count); end
        do_op(1, 1, 1, 22'h000200);
        n_tests++; if (o_pop_addr !== 22'h000202) begin n_fail++; $display("FAIL repl_addr got %h want 000202", o_pop_addr); end
        n_tests++; if (o_count !== 4'd1)  begin n_fail++; $display("FAIL repl_count got %0d want 1", o_count); end
        n_tests++; if (o_tos !== exp_tos) begin n_fail++; $display("FAIL repl_tos got %0d want %0d", o_tos, exp_tos); end
        do_op(1, 0, 1, 22'h0); exp_tos--;
        do_op(1, 1, 1, 22'h000300); exp_tos++;
        n_tests++; if (o_count !== 4'd1)  begin n_fail++; $display("FAIL repl_empty_count got %0d want 1", o_count); end
        n_tests++; if (o_pop_addr !== 22'h000302) begin n_fail++; $display("FAIL repl_empty_addr got %h want 000302", o_pop_addr); end
        n_tests++; if (o_tos !== exp_tos) begin n_fail++; $display("FAIL repl_empty_tos got %0d want %0d", o_tos, exp_tos); end
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_jal_inst = 1'b0; i_jr_inst = 1'b0;
        i_branch_address = '0; i_restore = 1'b0; i_restore_tos = '0; i_restore_cnt = '0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow_gating();
        test_restore();
        test_wrap_replace();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
